stage2_ct_buffer_ctrl: RTL and testbench

//  Sequencer for the stage-2 Ct buffer: 16-lane x 18-bit Ct rows, 64 rows deep, two read-address RAM copies.
//  - Fill phase: accepts Ct rows from the upstream cell with a valid/ready handshake and drives the write enable and address.
//  - Drain phase: issues paired read addresses {k, k+1} and presents 32 Ct lanes per beat downstream with a valid/ready handshake.
//  - Replaces free-running enables with frame-level flow control.

---
 rtl/ct_buf_pkg.sv | 20 ++
 rtl/ct_buf_ptr.sv | 23 ++
 rtl/stage2_ct_buffer_ctrl.sv | 133 +++++++++++++
 tb/tb_stage2_ct_buffer_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_buf_pkg.sv
// Shared constants for the stage-2 Ct buffer sequencer: state encoding and buffer geometry.
package ct_buf_pkg;

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_FILL  = ST_FILL,
        S_PRIME = ST_PRIME,
        S_DRAIN = ST_DRAIN
    } ct_buf_state_t;

    localparam int unsigned CT_W      = 18;
    localparam int unsigned CT_LANES  = 16;
    localparam int unsigned CT_DEPTH  = 64;
    localparam int unsigned CT_ADDR_W = 6;
    localparam int unsigned CT_BEATS  = CT_DEPTH / 2;

endpackage

// File: rtl/ct_buf_ptr.sv
// Wrapping pointer: counts 0..MAX on inc, returns to 0 after MAX or on clr.
module ct_buf_ptr #(
    parameter int unsigned MAX = 63,
    parameter int unsigned W   = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == W'(MAX)) ? '0 : ptr + W'(1);
        end
    end

endmodule

// File: rtl/stage2_ct_buffer_ctrl.sv
// Fill/prime/drain sequencer for the stage-2 Ct buffer (two read-address RAM copies).
// Optional sticky protocol error flag o_err built when CT_BUF_ERR_FLAG_EN is defined.
module stage2_ct_buffer_ctrl
    import ct_buf_pkg::*;
#(
    parameter int unsigned DEPTH  = CT_DEPTH,
    parameter int unsigned ADDR_W = CT_ADDR_W,
    parameter int unsigned BEATS  = CT_BEATS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              buf_wen,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic [ADDR_W-1:0] buf_raddr_0,
    output logic [ADDR_W-1:0] buf_raddr_1,
    input  logic              out_ready,
    output logic              o_valid,
    output logic              o_last,
    output logic              o_frame_done
`ifdef CT_BUF_ERR_FLAG_EN
    ,
    output logic              o_err
`endif
);

    localparam int unsigned RD_W = $clog2(BEATS);

    ct_buf_state_t     state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [RD_W-1:0]   rd_ptr;
    logic              accept;
    logic [ADDR_W:0]   rd_base;
    logic [ADDR_W:0]   rd_next_base;

    assign buf_wen   = in_ready && in_valid;
    assign buf_waddr = wr_ptr;
    assign accept    = o_valid && out_ready;

    ct_buf_ptr #(.MAX(DEPTH - 1), .W(ADDR_W)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (buf_wen),
        .clr   (state != S_FILL),
        .ptr   (wr_ptr)
    );

    ct_buf_ptr #(.MAX(BEATS - 1), .W(RD_W)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .clr   (state == S_FILL),
        .ptr   (rd_ptr)
    );

    // Look one beat ahead on accept so the RAM q advances with no bubble; hold under stall.
    assign rd_base      = (ADDR_W + 1)'(rd_ptr) << 1;
    assign rd_next_base = ((ADDR_W + 1)'(rd_ptr) + (ADDR_W + 1)'(1)) << 1;
    assign buf_raddr_0  = ADDR_W'(accept ? rd_next_base : rd_base);
    assign buf_raddr_1  = buf_raddr_0 + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_FILL;
            in_ready     <= 1'b1;
            o_valid      <= 1'b0;
            o_last       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            case (state)
                S_FILL: begin
                    if (buf_wen && wr_ptr == ADDR_W'(DEPTH - 1)) begin
                        state    <= S_PRIME;
                        in_ready <= 1'b0;
                    end
                end
                S_PRIME: begin
                    state   <= S_DRAIN;
                    o_valid <= 1'b1;
                    o_last  <= 1'b0;
                end
                S_DRAIN: begin
                    if (accept) begin
                        o_last <= (rd_ptr == RD_W'(BEATS - 2));
                        if (o_last) begin
                            state        <= S_FILL;
                            in_ready     <= 1'b1;
                            o_valid      <= 1'b0;
                            o_last       <= 1'b0;
                            o_frame_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= S_FILL;
                    in_ready <= 1'b1;
                    o_valid  <= 1'b0;
                    o_last   <= 1'b0;
                end
            endcase
        end
    end

`ifdef CT_BUF_ERR_FLAG_EN
    logic o_valid_d;
    logic last_seen;

    // Overrun while not filling, or o_valid dropping without the final beat being taken.
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_err     <= 1'b0;
            o_valid_d <= 1'b0;
            last_seen <= 1'b0;
        end else begin
            o_valid_d <= o_valid;
            if (in_valid && state != S_FILL) begin
                o_err <= 1'b1;
            end
            if (o_valid_d && !o_valid) begin
                if (!last_seen) begin
                    o_err <= 1'b1;
                end
                last_seen <= 1'b0;
            end else if (accept && o_last) begin
                last_seen <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stage2_ct_buffer_ctrl.sv
// Directed bench for stage2_ct_buffer_ctrl with a two-copy RAM model driven by the DUT addresses.
module tb_stage2_ct_buffer_ctrl;

    localparam int DEPTH = 64;
    localparam int BEATS = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       buf_wen;
    logic [5:0] buf_waddr;
    logic [5:0] buf_raddr_0;
    logic [5:0] buf_raddr_1;
    logic       out_ready;
    logic       o_valid;
    logic       o_last;
    logic       o_frame_done;
`ifdef CT_BUF_ERR_FLAG_EN
    logic       o_err;
`endif

    logic [17:0] wdata;
    logic [17:0] mem0 [DEPTH];
    logic [17:0] mem1 [DEPTH];
    logic [17:0] q0;
    logic [17:0] q1;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    stage2_ct_buffer_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .buf_wen      (buf_wen),
        .buf_waddr    (buf_waddr),
        .buf_raddr_0  (buf_raddr_0),
        .buf_raddr_1  (buf_raddr_1),
        .out_ready    (out_ready),
        .o_valid      (o_valid),
        .o_last       (o_last),
        .o_frame_done (o_frame_done)
`ifdef CT_BUF_ERR_FLAG_EN
        ,
        .o_err        (o_err)
`endif
    );

    // RAM copies with 1-cycle read latency; lane 0 of each row stands in for the row
    always @(posedge clk) begin
        if (buf_wen) begin
            mem0[buf_waddr] <= wdata;
            mem1[buf_waddr] <= wdata;
        end
        q0 <= mem0[buf_raddr_0];
        q1 <= mem1[buf_raddr_1];
    end

    typedef struct {
        logic rdy;
        int   raddr0;
        int   beat;
    } vec_t;

    vec_t tbl [8];
    logic pat [4];

    function automatic logic [17:0] tag(input int base, input int r);
        return 18'(base + r * 16);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_frame(input int base, output int cyc);
        cyc = 0;
        for (int r = 0; r < DEPTH; r++) begin
            in_valid = 1'b1;
            wdata    = tag(base, r);
            #1;
            chk("fill_wen", buf_wen, 1);
            chk("fill_waddr", buf_waddr, r);
            chk("fill_in_ready", in_ready, 1);
            chk("fill_o_valid", o_valid, 0);
            if (r == 1) chk("frame_done_width", o_frame_done, 0);
            tick();
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic prime_check(input logic keep_valid);
        in_valid = keep_valid;
        #1;
        chk("prime_in_ready", in_ready, 0);
        chk("prime_wen", buf_wen, 0);
        chk("prime_raddr0", buf_raddr_0, 0);
        chk("prime_raddr1", buf_raddr_1, 1);
        chk("prime_o_valid", o_valid, 0);
        tick();
    endtask

    task automatic drain_ready(input int base, input logic keep_valid, output int cyc);
        cyc = 0;
        for (int b = 0; b < BEATS; b++) begin
            in_valid  = keep_valid;
            out_ready = 1'b1;
            #1;
            chk("drain_o_valid", o_valid, 1);
            chk("drain_o_last", o_last, (b == BEATS - 1));
            chk("drain_q0", q0, tag(base, 2 * b));
            chk("drain_q1", q1, tag(base, 2 * b + 1));
            chk("drain_wen", buf_wen, 0);
            chk("drain_in_ready", in_ready, 0);
            chk("drain_raddr0", buf_raddr_0, (b == BEATS - 1) ? 0 : 2 * b + 2);
            chk("drain_raddr1", buf_raddr_1, (b == BEATS - 1) ? 1 : 2 * b + 3);
            chk("drain_frame_done", o_frame_done, 0);
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("end_frame_done", o_frame_done, 1);
        chk("end_o_valid", o_valid, 0);
        chk("end_o_last", o_last, 0);
        chk("end_in_ready", in_ready, 1);
    endtask

    initial begin
        int c_fill;
        int c_drain;
        int beat;
        int cyc;
        int fd;

        // Stall pattern 1,0,0,1: first 8 drain cycles, hand-computed
        tbl[0] = '{1'b1, 2, 0};
        tbl[1] = '{1'b0, 2, 1};
        tbl[2] = '{1'b0, 2, 1};
        tbl[3] = '{1'b1, 4, 1};
        tbl[4] = '{1'b1, 6, 2};
        tbl[5] = '{1'b0, 6, 3};
        tbl[6] = '{1'b0, 6, 3};
        tbl[7] = '{1'b1, 8, 3};
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        reset     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        wdata     = '0;
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_last", o_last, 0);
        chk("rst_frame_done", o_frame_done, 0);
        chk("rst_raddr0", buf_raddr_0, 0);
`ifdef CT_BUF_ERR_FLAG_EN
        chk("rst_o_err", o_err, 0);
`endif
        reset = 1'b1;

        // Frame with in_valid held high through prime and drain
        fill_frame(0, c_fill);
        prime_check(1'b1);
        drain_ready(0, 1'b1, c_drain);
`ifdef CT_BUF_ERR_FLAG_EN
        chk("overrun_o_err", o_err, 1);
`endif

        // Stalled drain
        fill_frame(4096, c_fill);
        prime_check(1'b0);
        beat = 0;
        fd   = 0;
        for (int i = 0; i < 8; i++) begin
            out_ready = tbl[i].rdy;
            #1;
            chk("stall_tbl_beat", beat, tbl[i].beat);
            chk("stall_tbl_raddr0", buf_raddr_0, tbl[i].raddr0);
            chk("stall_tbl_raddr1", buf_raddr_1, tbl[i].raddr0 + 1);
            chk("stall_tbl_q0", q0, tag(4096, 2 * tbl[i].beat));
            chk("stall_tbl_q1", q1, tag(4096, 2 * tbl[i].beat + 1));
            chk("stall_tbl_o_valid", o_valid, 1);
            tick();
            if (tbl[i].rdy) beat++;
            if (o_frame_done) fd++;
        end
        cyc = 8;
        while (beat < BEATS && cyc < 400) begin
            out_ready = pat[cyc % 4];
            #1;
            chk("stall_o_valid", o_valid, 1);
            chk("stall_o_last", o_last, (beat == BEATS - 1));
            chk("stall_q0", q0, tag(4096, 2 * beat));
            chk("stall_q1", q1, tag(4096, 2 * beat + 1));
            if (out_ready) chk("stall_raddr0_acc", buf_raddr_0, (beat == BEATS - 1) ? 0 : 2 * beat + 2);
            else           chk("stall_raddr0_hold", buf_raddr_0, 2 * beat);
            tick();
            if (out_ready) beat++;
            if (o_frame_done) fd++;
            cyc++;
        end
        chk("stall_timeout", (cyc < 400), 1);
        chk("stall_cycles", cyc, 64);
        out_ready = 1'b0;
        chk("stall_o_valid_end", o_valid, 0);
        tick();
        if (o_frame_done) fd++;
        chk("stall_fd_count", fd, 1);

        // Reset mid-drain at beat 10, then a fresh frame
        fill_frame(8192, c_fill);
        prime_check(1'b0);
        for (int b = 0; b < 10; b++) begin
            out_ready = 1'b1;
            #1;
            chk("pre_rst_q0", q0, tag(8192, 2 * b));
            tick();
        end
        reset = 1'b0;
        tick();
        reset     = 1'b1;
        out_ready = 1'b0;
        chk("midrst_o_valid", o_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_o_last", o_last, 0);
        chk("midrst_raddr0", buf_raddr_0, 0);
`ifdef CT_BUF_ERR_FLAG_EN
        chk("midrst_o_err", o_err, 0);
`endif
        fill_frame(12288, c_fill);
        prime_check(1'b0);
        drain_ready(12288, 1'b0, c_drain);

        // Two back-to-back frames, downstream always ready
        for (int f = 0; f < 2; f++) begin
            fill_frame(16384 + f * 4096, c_fill);
            prime_check(1'b0);
            drain_ready(16384 + f * 4096, 1'b0, c_drain);
            chk("frame_cycles", c_fill + 1 + c_drain, 97);
        end
`ifdef CT_BUF_ERR_FLAG_EN
        chk("clean_o_err", o_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
